riscv_regfile_mp: RTL
=====================

RISCV_REGFILE_MP -- requirements
Module: riscv_regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; legal values are 16 (RV32E) or 32; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRP, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port ready, output, 1, high once the post-reset clear is complete.
REQ-008 SHALL have port cs, input, 1, read enable; read outputs update only when cs=1.
REQ-009 SHALL have port raddr, input, NRP*AW, packed read indices, where port i is bits [i*AW +: AW].
REQ-010 SHALL have port rdata, output, NRP*XLEN, packed registered read data.
REQ-011 SHALL have port rbusy, output, NRP, scoreboard busy bit per read port, registered with rdata.
REQ-012 SHALL have ports wen (input, 1), waddr (input, AW) and wdata (input, XLEN), forming the write port.
REQ-013 SHALL have ports rsv (input, 1) and rsv_addr (input, AW), which mark a destination pending write.
REQ-014 SHALL have port rsv_ok, output, 1, combinational; it is 1 when the rsv_addr entry is not busy or the index is 0.

Function
REQ-015 SHALL be in state CLEAR after reset: one register is zeroed per cycle, for indices 0..NREGS-1, then the block moves to RUN. CLEAR lasts exactly NREGS cycles and ready=0 throughout.
REQ-016 SHALL ignore cs, wen and rsv in CLEAR; rdata and rbusy hold 0.
REQ-017 SHALL, in RUN with cs=1, present rdata[i]=reg[raddr[i]] and rbusy[i]=busy[raddr[i]] one cycle after sampling (latency 1). With cs=0, rdata and rbusy hold their values.
REQ-018 SHALL always read index 0 as 0; writes and reservations to index 0 are discarded, and busy[0] stays 0.
REQ-019 SHALL write wdata to reg[waddr] at the clock edge when wen=1 in RUN.
REQ-020 SHALL forward data when BYPASS=1 and wen=1 and raddr[i]==waddr!=0 in the same cycle: rdata[i] gets wdata. When BYPASS=0, rdata[i] gets the old value.
REQ-021 SHALL set busy[rsv_addr] at the edge when rsv=1 in RUN, and clear busy[waddr] at the edge when wen=1.
REQ-022 SHALL, when rsv and wen target the same nonzero index in the same cycle, let the reservation win: data is written and busy ends at 1.
REQ-023 SHALL compute rbusy from post-update busy for same-cycle events, so bypassed reads report busy=0 unless REQ-022 applies.
REQ-024 SHALL accept rsv while the index is already busy; it stays busy, and there is no counting.
REQ-025 SHALL support multiple read ports with identical addresses; each port returns identical data.
REQ-026 SHALL, in CLEAR, keep the clear counter at AW bits with no wrap. On reaching NREGS-1, the block enters RUN on the next edge.

Reset
REQ-027 SHALL, on rst assertion (asynchronous), immediately force state to CLEAR, the counter to 0, ready=0, rdata=0, rbusy=0 and all busy bits to 0.
REQ-028 SHALL NOT asynchronously reset the storage array; contents are zeroed only by CLEAR.
REQ-029 SHALL restart CLEAR from index 0 if rst is asserted mid-CLEAR or mid-RUN, abandoning any pending write.
REQ-030 SHALL deassert reset synchronously relative to clk; the first CLEAR write occurs on the first edge after deassertion.

Structure
REQ-031 SHALL take XLEN default, the reg-index width, and the state enum (CLEAR, RUN) from shared package riscv_pkg.
REQ-032 SHALL implement the busy bits and rsv_ok in sub-module riscv_regfile_scoreboard (ports: clk, rst, set, set_addr, clr, clr_addr, query addresses, busy outputs).
REQ-033 SHALL infer the storage as a single write-port array with NRP read ports, with no per-entry async reset.

Verification
REQ-034 SHALL cover this scenario: rst pulse, then idle. Expected: ready=0 for exactly 32 cycles, then ready=1; reading all 32 indices returns 0.
REQ-035 SHALL cover this scenario: write 0xDEADBEEF to x5, then read x5 on port 0 and x5 on port 1 the next cycle. Expected: both rdata = 0xDEADBEEF one cycle later.
REQ-036 SHALL cover this scenario: same-cycle wen x7 = 0x12345678 with read x7, first with BYPASS=1 and then with BYPASS=0. Expected: rdata = 0x12345678 for BYPASS=1 and the previous value for BYPASS=0.
REQ-037 SHALL cover this scenario: write 0xFFFFFFFF to x0, rsv x0, then read x0. Expected: rdata = 0, rbusy = 0, rsv_ok = 1.
REQ-038 SHALL cover this scenario: rsv x3, then rsv_addr=3, then wen x3 with rsv x3 in the same cycle. Expected: busy is 1 after the first rsv and rsv_ok = 0; after the simultaneous cycle busy is still 1 and data is written.
REQ-039 SHALL cover this scenario: rst asserted at CLEAR cycle 10 with NREGS=16. Expected: ready=0 for 16 further cycles after deassertion, then all registers read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file widths and the clear/run state type
package riscv_pkg;
  localparam int XLEN_DFLT = 32;
  localparam int NREGS_DFLT = 32;

  typedef enum logic {CLEAR, RUN} rf_state_e;

  function automatic int reg_aw(input int nregs);
    return $clog2(nregs);
  endfunction
endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// riscv_regfile_scoreboard: per-register pending-write busy bits with post-update query ports
module riscv_regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS = NREGS_DFLT,
  parameter int NRP = 2,
  localparam int AW = reg_aw(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set,
  input  logic [AW-1:0]   set_addr,
  input  logic            clr,
  input  logic [AW-1:0]   clr_addr,
  input  logic [NRP*AW-1:0] qaddr,
  output logic [NRP-1:0]  qbusy,
  output logic            set_ok
);
  logic [NREGS-1:0] busy, nxt;

  // a reservation beats a same-cycle completion; x0 can never be busy
  always_comb begin
    nxt = busy;
    if (clr) nxt[clr_addr] = 1'b0;
    if (set) nxt[set_addr] = 1'b1;
    nxt[0] = 1'b0;
  end

  // busy state, cleared immediately on reset
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= nxt;

  // queries see the post-update value so same-cycle events are reflected
  for (genvar i = 0; i < NRP; i++) begin : g_q
    assign qbusy[i] = nxt[qaddr[i*AW +: AW]];
  end

  assign set_ok = !busy[set_addr];
endmodule

// File: rtl/riscv_regfile_mp.sv
// riscv_regfile_mp: multi-read-port register file with post-reset clear, bypass and busy scoreboard
module riscv_regfile_mp
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DFLT,
  parameter int NREGS = NREGS_DFLT,
  parameter int NRP = 2,
  parameter int BYPASS = 1,
  localparam int AW = reg_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              cs,
  input  logic [NRP*AW-1:0] raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]    rbusy,
  input  logic              wen,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              rsv,
  input  logic [AW-1:0]     rsv_addr,
  output logic              rsv_ok
);
  rf_state_e state, state_nxt;
  logic [AW-1:0] cnt;
  logic run;
  logic [NRP-1:0] qbusy;
  logic [XLEN-1:0] mem [NREGS];

  // state register and clear counter, which saturates at the last index
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= (state == CLEAR && cnt != AW'(NREGS - 1)) ? cnt + 1'b1 : cnt;
    end

  // leave CLEAR once the last register has been zeroed
  always_comb state_nxt = (state == CLEAR && cnt == AW'(NREGS - 1)) ? RUN : state;

  // run enables all external activity and signals readiness
  always_comb begin
    run = state == RUN;
    ready = run;
  end

  // storage: zero one entry per cycle in CLEAR, otherwise the single write port
  always_ff @(posedge clk)
    if (!run) mem[cnt] <= '0;
    else if (wen && waddr != '0) mem[waddr] <= wdata;

  riscv_regfile_scoreboard #(.NREGS(NREGS), .NRP(NRP)) u_sb (
    .clk(clk),
    .rst(rst),
    .set(run && rsv),
    .set_addr(rsv_addr),
    .clr(run && wen),
    .clr_addr(waddr),
    .qaddr(raddr),
    .qbusy(qbusy),
    .set_ok(rsv_ok)
  );

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [XLEN-1:0] rd;
    logic bz;
    assign a = raddr[i*AW +: AW];
    // registered read with optional same-cycle write forwarding
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rd <= '0;
        bz <= 1'b0;
      end else if (run && cs) begin
        rd <= a == '0 ? '0 : (BYPASS != 0 && wen && a == waddr) ? wdata : mem[a];
        bz <= qbusy[i];
      end
    assign rdata[i*XLEN +: XLEN] = rd;
    assign rbusy[i] = bz;
  end
endmodule
